// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared definitions for the mux scan sequencer: FSM state encoding,
//   channel count and channel-index width.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// dwell_timer
//   Counts clock cycles a channel has been selected. Raises 'last' while the
//   count sits at DWELL-1 so the owner can sample and advance on that edge.
//   The count wraps to zero on the edge where 'last' is high.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (count -> 0)
//   clr   synchronous clear (count -> 0), takes priority over en
//   en    advance the count on this edge
//   last  high when count == DWELL-1
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    // DWELL >= 2, so $clog2 is at least 1; the guard keeps a 1-bit floor.
    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

    logic [CW-1:0] dwell_cnt;

    assign last = (dwell_cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dwell_cnt <= '0;
        end else if (en) begin
            if (last) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Drives the select lines of a 4-to-1 mux through channels 0..3, holding
//   each channel for DWELL cycles, samples the mux output at the end of each
//   dwell and publishes a 4-bit frame (bit n = channel n).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a scan (only looked at in IDLE)
//   cont         continuous mode, looked at only on the frame-end edge
//   y_in         mux output Y, assumed synchronous to clk
//   s1, s0       registered channel select to the mux
//   busy         high while scanning (directly reflects the FSM state)
//   frame        last completed frame, updated atomically
//   frame_valid  one-cycle pulse on the cycle frame takes a new value
//
// Output handshake: frame_valid is a valid-only strobe with no ready; the
// consumer must capture frame on the cycle frame_valid is high, although
// frame itself holds until the next pulse.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y_in,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic [3:0] frame,
    output logic       frame_valid
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t          state, state_n;
    logic [CH_W-1:0] ch, ch_n;
    // Channel 3 is never stored: it goes straight into the frame.
    logic [2:0]      shadow, shadow_n;
    logic [3:0]      frame_n;
    logic            frame_valid_n;
    logic            tmr_clr, tmr_en, tmr_last;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .last (tmr_last)
    );

    assign s1   = ch[1];
    assign s0   = ch[0];
    assign busy = (state == SCAN);

    always_comb begin
        state_n       = state;
        ch_n          = ch;
        shadow_n      = shadow;
        frame_n       = frame;
        frame_valid_n = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        case (state)
            IDLE: begin
                // Timer held at zero so the first dwell is full length.
                ch_n    = '0;
                tmr_clr = 1'b1;
                if (start) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                tmr_en = 1'b1;
                if (tmr_last) begin
                    if (ch == LAST_CH) begin
                        // Frame end: publish the whole frame in one edge.
                        frame_n       = {y_in, shadow};
                        frame_valid_n = 1'b1;
                        ch_n          = '0;
                        if (!cont) begin
                            state_n = IDLE;
                        end
                    end else begin
                        for (int n = 0; n < 3; n++) begin
                            if (ch == CH_W'(n)) begin
                                shadow_n[n] = y_in;
                            end
                        end
                        ch_n = ch + CH_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ch_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ch          <= ch_n;
            shadow      <= shadow_n;
            frame       <= frame_n;
            frame_valid <= frame_valid_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//   Two sequencers (DWELL=4 and DWELL=2) each scanning a behavioural
//   4-to-1 mux. Expected frames and their arrival cycles are queued when a
//   scan is launched and checked when frame_valid is seen.
module tb_mux_scan_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT, DWELL=4 ----------------
    logic       start4 = 1'b0, cont4 = 1'b0;
    logic [3:0] i4 = 4'b0000;
    logic       y4, s1_4, s0_4, busy4, fv4;
    logic [3:0] frame4;
    assign y4 = i4[{s1_4, s0_4}];

    mux_scan_sequencer #(.DWELL(4)) dut4 (
        .clk (clk), .rst (rst), .start (start4), .cont (cont4), .y_in (y4),
        .s1 (s1_4), .s0 (s0_4), .busy (busy4), .frame (frame4),
        .frame_valid (fv4)
    );

    // ---------------- DUT, DWELL=2 ----------------
    logic       start2 = 1'b0, cont2 = 1'b0;
    logic [3:0] i2 = 4'b0000;
    logic       y2, s1_2, s0_2, busy2, fv2;
    logic [3:0] frame2;
    assign y2 = i2[{s1_2, s0_2}];

    mux_scan_sequencer #(.DWELL(2)) dut2 (
        .clk (clk), .rst (rst), .start (start2), .cont (cont2), .y_in (y2),
        .s1 (s1_2), .s0 (s0_2), .busy (busy2), .frame (frame2),
        .frame_valid (fv2)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [3:0] exp4_q[$];
    int         expt4_q[$];
    logic [3:0] exp2_q[$];
    int         expt2_q[$];

    always @(negedge clk) begin
        if (!rst && fv4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                check("fv4_unexpected", 32'(fv4), 32'd0);
            end else begin
                check("frame4", 32'(frame4), 32'(exp4_q.pop_front()));
                check("fv4_cycle", 32'(cyc), 32'(expt4_q.pop_front()));
            end
        end
        if (!rst && fv2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                check("fv2_unexpected", 32'(fv2), 32'd0);
            end else begin
                check("frame2", 32'(frame2), 32'(exp2_q.pop_front()));
                check("fv2_cycle", 32'(cyc), 32'(expt2_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raises start4 on a negedge; returns the cycle number of edge E0.
    task automatic launch4(input logic [3:0] pat, input logic c, output int e0);
        @(negedge clk);
        i4     = pat;
        cont4  = c;
        start4 = 1'b1;
        e0     = cyc + 1;
    endtask

    // One non-continuous frame on dut4, checking selects and busy each cycle.
    task automatic single_frame4(input logic [3:0] pat);
        int e0;
        launch4(pat, 1'b0, e0);
        exp4_q.push_back(pat);
        expt4_q.push_back(e0 + 16);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            check("sel4", 32'({s1_4, s0_4}), 32'((k / 4) % 4));
            check("busy4", 32'(busy4), 32'(k < 16));
        end
        @(negedge clk);
        check("fv4_one_cycle", 32'(fv4), 32'd0);
        check("frame4_hold", 32'(frame4), 32'(pat));
        check("q4_drained", 32'(exp4_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        logic [3:0] r;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_sel4", 32'({s1_4, s0_4}), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_frame4", 32'(frame4), 32'd0);
        check("rst_fv4", 32'(fv4), 32'd0);
        check("rst_sel2", 32'({s1_2, s0_2}), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single frame, i3..i0 = 1,1,0,1
        single_frame4(4'b1101);

        // 2: continuous, input change during frame 2 channel-0 window
        launch4(4'b0001, 1'b1, e0);
        exp4_q.push_back(4'b0001); expt4_q.push_back(e0 + 16);
        exp4_q.push_back(4'b0110); expt4_q.push_back(e0 + 32);
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (k == 16) i4 = 4'b0110;
            if (k == 28) cont4 = 1'b0;
            check("t2_sel4", 32'({s1_4, s0_4}), 32'((k / 4) % 4));
            check("t2_busy4", 32'(busy4), 32'(k < 32));
        end
        @(negedge clk);
        check("t2_q4_drained", 32'(exp4_q.size()), 32'd0);

        // 3: second start mid-scan is ignored
        launch4(4'b0110, 1'b0, e0);
        exp4_q.push_back(4'b0110); expt4_q.push_back(e0 + 16);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            start4 = (k == 4);
            if (k <= 16) begin
                check("t3_sel4", 32'({s1_4, s0_4}), 32'((k / 4) % 4));
                check("t3_busy4", 32'(busy4), 32'(k < 16));
            end
        end
        check("t3_q4_drained", 32'(exp4_q.size()), 32'd0);

        // 4: reset mid-scan discards the partial frame
        launch4(4'b1011, 1'b0, e0);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                rst = 1'b0;
                check("t4_sel4", 32'({s1_4, s0_4}), 32'd0);
                check("t4_busy4", 32'(busy4), 32'd0);
                check("t4_frame4", 32'(frame4), 32'd0);
            end
            if (k > 7) check("t4_idle4", 32'(busy4), 32'd0);
        end

        // 5: cont dropped mid second frame
        r = 4'($urandom_range(1, 15));
        launch4(r, 1'b1, e0);
        exp4_q.push_back(r); expt4_q.push_back(e0 + 16);
        exp4_q.push_back(r); expt4_q.push_back(e0 + 32);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (k == 19) cont4 = 1'b0;
            check("t5_busy4", 32'(busy4), 32'(k < 32));
        end
        check("t5_q4_drained", 32'(exp4_q.size()), 32'd0);

        // random single frames
        for (int n = 0; n < 3; n++) begin
            single_frame4(4'($urandom_range(0, 15)));
        end

        // 6: DWELL=2, i3..i0 = 1,0,1,0
        @(negedge clk);
        i2     = 4'b1010;
        start2 = 1'b1;
        e0     = cyc + 1;
        exp2_q.push_back(4'b1010); expt2_q.push_back(e0 + 8);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            check("t6_sel2", 32'({s1_2, s0_2}), 32'((k / 2) % 4));
            check("t6_busy2", 32'(busy2), 32'(k < 8));
        end
        repeat (2) @(negedge clk);
        check("t6_frame2_hold", 32'(frame2), 32'h0a);
        check("q2_drained", 32'(exp2_q.size()), 32'd0);
        check("q4_final", 32'(exp4_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
